// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: holds the PC, reads instruction memory over req/ack, and advances on commit.
// Optional FETCH_MISALIGN_CHECK_EN: halt with a sticky error on a misaligned target instead of forcing alignment.
module instr_fetch_unit #(
    parameter int          XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h00000000,
    parameter logic [31:0] NOP_WORD = 32'h00000013
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [31:0]     imem_rdata,
    output logic [31:0]     instr,
    output logic [6:0]      opc,
    output logic [2:0]      f3,
    output logic            instr_valid,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
    input  logic            commit,
    input  logic            PC_src,
    input  logic            is_jalr,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] alu_result,
    output logic            misalign_err
);

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_VALID, S_HALT} state_t;

    state_t          state, state_nxt;
    logic [XLEN-1:0] target, next_pc;
    logic            load_instr, load_pc;

    assign opc       = instr[6:0];
    assign f3        = instr[14:12];
    assign pc_plus4  = pc + XLEN'(4);
    assign imem_addr = pc;

    // JALR clears bit 0 of rs1+imm and wins over a taken branch
    always_comb begin
        target = pc_plus4;
        if (is_jalr)
            target = alu_result & ~XLEN'(1);
        else if (PC_src)
            target = pc + imm;
    end

`ifdef FETCH_MISALIGN_CHECK_EN
    logic misaligned, set_err, err_q;
    assign next_pc      = target;
    assign misaligned   = |target[1:0];
    assign misalign_err = err_q;
`else
    assign next_pc      = target & ~XLEN'(3);
    assign misalign_err = 1'b0;
`endif

    always_comb begin
        state_nxt   = state;
        load_instr  = 1'b0;
        load_pc     = 1'b0;
        imem_req    = 1'b0;
        instr_valid = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
        set_err     = 1'b0;
`endif
        case (state)
            S_IDLE: state_nxt = S_REQ;
            S_REQ, S_WAIT: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    load_instr = 1'b1;
                    state_nxt  = S_VALID;
                end else begin
                    state_nxt  = S_WAIT;
                end
            end
            S_VALID: begin
                instr_valid = 1'b1;
                if (commit) begin
`ifdef FETCH_MISALIGN_CHECK_EN
                    if (misaligned) begin
                        set_err   = 1'b1;
                        state_nxt = S_HALT;
                    end else begin
                        load_pc   = 1'b1;
                        state_nxt = S_REQ;
                    end
`else
                    load_pc   = 1'b1;
                    state_nxt = S_REQ;
`endif
                end
            end
            S_HALT:  state_nxt = S_HALT;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            pc    <= RESET_PC;
            instr <= NOP_WORD;
        end else begin
            state <= state_nxt;
            if (load_instr) instr <= imem_rdata;
            if (load_pc)    pc    <= next_pc;
        end
    end

`ifdef FETCH_MISALIGN_CHECK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)          err_q <= 1'b0;
        else if (set_err) err_q <= 1'b1;
    end
`endif

endmodule
